// File: rtl/vruntime_monitor_pkg.sv
// Shared definitions for the vector runtime monitor: FSM states, counter
// slots and the read-port address map.
package vruntime_monitor_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned NrCnt = 4;

    // Counter slot indices; the buffer addresses reuse the same numbering.
    localparam int unsigned CntRuntime = 0;
    localparam int unsigned CntDcache  = 1;
    localparam int unsigned CntIcache  = 2;
    localparam int unsigned CntSbFull  = 3;

    localparam logic [2:0] AddrRuntimeBuf = 3'd0;
    localparam logic [2:0] AddrDcacheBuf  = 3'd1;
    localparam logic [2:0] AddrIcacheBuf  = 3'd2;
    localparam logic [2:0] AddrSbFullBuf  = 3'd3;
    localparam logic [2:0] AddrLiveRun    = 3'd4;
    localparam logic [2:0] AddrStatus     = 3'd5;

endpackage

// File: rtl/vruntime_monitor_if.sv
// Register read port of the runtime monitor; the monitor is the slave side.
interface vruntime_monitor_if #(
    parameter int unsigned CntWidth = 64
);
    logic                rd_req_i;
    logic [2:0]          rd_addr_i;
    logic                rd_valid_o;
    logic [CntWidth-1:0] rd_data_o;

    modport master (
        output rd_req_i,
        output rd_addr_i,
        input  rd_valid_o,
        input  rd_data_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_addr_i,
        output rd_valid_o,
        output rd_data_o
    );
endinterface

// File: rtl/vruntime_sat_cnt.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module vruntime_sat_cnt #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/vruntime_monitor.sv
// Measures how long vector work keeps Ara busy and how often CVA6 stalls meanwhile,
// snapshotting the counters whenever outstanding vector work drains.
module vruntime_monitor
    import vruntime_monitor_pkg::*;
#(
    parameter int unsigned CntWidth = 64,
    parameter int unsigned NrRegs   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sw_en_i,
    input  logic             clear_i,
    input  logic             vinsn_valid_i,
    input  logic             ara_idle_i,
    input  logic             dcache_miss_i,
    input  logic             icache_miss_i,
    input  logic             sb_full_i,
    vruntime_monitor_if.slave rd_bus,
    output logic             snapshot_o,
    output logic             running_o
);

    state_e r_state;
    state_e w_stateNext;

    logic                r_pending;
    logic                r_snapshot;
    logic                w_snapFire;
    logic [NrCnt-1:0]    w_cntEn;
    logic [CntWidth-1:0] w_cnt [NrCnt];
    logic [CntWidth-1:0] r_buf [NrCnt];
    logic [CntWidth-1:0] w_rdMux;
    logic                r_rdValid;
    logic [CntWidth-1:0] r_rdData;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Leaving RUN waits until software disarms and Ara has fully drained.
    always_comb begin
        w_stateNext = r_state;
        if (clear_i) begin
            w_stateNext = StIdle;
        end else begin
            case (r_state)
                StIdle:  if (vinsn_valid_i && sw_en_i) w_stateNext = StRun;
                StRun:   if (!sw_en_i && ara_idle_i && !vinsn_valid_i) w_stateNext = StIdle;
                default: w_stateNext = StIdle;
            endcase
        end
    end

    assign running_o = (r_state == StRun);

    assign w_cntEn = {sb_full_i, icache_miss_i, dcache_miss_i, 1'b1} & {NrCnt{running_o}};

    for (genvar i = 0; i < NrCnt; i++) begin : gen_cnt
        vruntime_sat_cnt #(
            .Width (CntWidth)
        ) i_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .en_i    (w_cntEn[i]),
            .cnt_o   (w_cnt[i])
        );
    end

    // A dispatch in the same cycle as idle means more work is coming, so no snapshot yet.
    assign w_snapFire = r_pending && ara_idle_i && !vinsn_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending  <= 1'b0;
            r_snapshot <= 1'b0;
        end else if (clear_i) begin
            r_pending  <= 1'b0;
            r_snapshot <= 1'b0;
        end else begin
            r_snapshot <= w_snapFire;
            if (vinsn_valid_i) begin
                r_pending <= 1'b1;
            end else if (w_snapFire) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign snapshot_o = r_snapshot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrCnt; i++) r_buf[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NrCnt; i++) r_buf[i] <= '0;
        end else if (w_snapFire) begin
            for (int i = 0; i < NrCnt; i++) r_buf[i] <= w_cnt[i];
        end
    end

    always_comb begin
        w_rdMux = '0;
        if (32'(rd_bus.rd_addr_i) < NrRegs) begin
            case (rd_bus.rd_addr_i)
                AddrRuntimeBuf: w_rdMux = r_buf[CntRuntime];
                AddrDcacheBuf:  w_rdMux = r_buf[CntDcache];
                AddrIcacheBuf:  w_rdMux = r_buf[CntIcache];
                AddrSbFullBuf:  w_rdMux = r_buf[CntSbFull];
                AddrLiveRun:    w_rdMux = w_cnt[CntRuntime];
                AddrStatus:     w_rdMux[1:0] = {running_o, r_pending};
                default:        w_rdMux = '0;
            endcase
        end
    end

    // Read data is captured at request time and held until the next request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= rd_bus.rd_req_i;
            if (rd_bus.rd_req_i) begin
                r_rdData <= w_rdMux;
            end
        end
    end

    assign rd_bus.rd_valid_o = r_rdValid;
    assign rd_bus.rd_data_o  = r_rdData;

endmodule

// File: tb/tb_vruntime_monitor.sv
// Drives a 64-bit and a 4-bit monitor with identical stimulus and checks both
// against a cycle-level behavioural model of the counting/snapshot rules.
module tb_vruntime_monitor;

    typedef struct packed {
        logic       sw;
        logic       clr;
        logic       vi;
        logic       idle;
        logic       dm;
        logic       im;
        logic       sb;
        logic       req;
        logic [2:0] addr;
    } stim_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic sw_en, clear, vinsn, idle, dmiss, imiss, sbfull;
    logic snap64, snap4, run64, run4;

    int total = 0;
    int bad = 0;

    vruntime_monitor_if #(.CntWidth(64)) bus64 ();
    vruntime_monitor_if #(.CntWidth(4))  bus4 ();

    vruntime_monitor #(.CntWidth(64), .NrRegs(8)) dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .sw_en_i(sw_en), .clear_i(clear),
        .vinsn_valid_i(vinsn), .ara_idle_i(idle), .dcache_miss_i(dmiss),
        .icache_miss_i(imiss), .sb_full_i(sbfull), .rd_bus(bus64),
        .snapshot_o(snap64), .running_o(run64)
    );

    vruntime_monitor #(.CntWidth(4), .NrRegs(8)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .sw_en_i(sw_en), .clear_i(clear),
        .vinsn_valid_i(vinsn), .ara_idle_i(idle), .dcache_miss_i(dmiss),
        .icache_miss_i(imiss), .sb_full_i(sbfull), .rd_bus(bus4),
        .snapshot_o(snap4), .running_o(run4)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is the 64-bit monitor, index 1 the 4-bit one.
    logic [63:0] mCnt [2][4];
    logic [63:0] mBuf [2][4];
    logic [63:0] mMax [2];
    logic [63:0] expData [2];
    bit          mRun, mPend, expValid, expSnap;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic stim_t mk(input logic sw, input logic clr, input logic vi, input logic idl,
                                 input logic dm, input logic im, input logic sb,
                                 input logic req, input logic [2:0] addr);
        stim_t s;
        s.sw = sw; s.clr = clr; s.vi = vi; s.idle = idl;
        s.dm = dm; s.im = im; s.sb = sb; s.req = req; s.addr = addr;
        return s;
    endfunction

    function automatic logic [63:0] readModel(input int d, input logic [2:0] addr);
        if (addr <= 3'd3) return mBuf[d][addr];
        if (addr == 3'd4) return mCnt[d][0];
        if (addr == 3'd5) return {62'd0, mRun, mPend};
        return 64'd0;
    endfunction

    function automatic logic [63:0] satInc(input logic [63:0] x, input logic [63:0] maxv);
        return (x == maxv) ? x : x + 64'd1;
    endfunction

    task automatic modelZero();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                mCnt[d][i] = 64'd0;
                mBuf[d][i] = 64'd0;
            end
        mRun = 1'b0;
        mPend = 1'b0;
        expSnap = 1'b0;
    endtask

    task automatic modelStep(input stim_t s);
        bit fire;
        bit ev [4];
        expValid = s.req;
        for (int d = 0; d < 2; d++)
            if (s.req) expData[d] = readModel(d, s.addr);
        if (s.clr) begin
            modelZero();
            return;
        end
        fire = mPend && s.idle && !s.vi;
        ev[0] = 1'b1; ev[1] = s.dm; ev[2] = s.im; ev[3] = s.sb;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                if (fire) mBuf[d][i] = mCnt[d][i];
                if (mRun && ev[i]) mCnt[d][i] = satInc(mCnt[d][i], mMax[d]);
            end
        if (s.vi) mPend = 1'b1;
        else if (fire) mPend = 1'b0;
        if (!mRun && s.vi && s.sw) mRun = 1'b1;
        else if (mRun && !s.sw && s.idle && !s.vi) mRun = 1'b0;
        expSnap = fire;
    endtask

    task automatic checkAll(input string ph);
        checkOutput({ph, "_valid64"}, {63'd0, bus64.rd_valid_o}, {63'd0, expValid});
        checkOutput({ph, "_valid4"},  {63'd0, bus4.rd_valid_o},  {63'd0, expValid});
        checkOutput({ph, "_data64"},  bus64.rd_data_o, expData[0]);
        checkOutput({ph, "_data4"},   {60'd0, bus4.rd_data_o}, expData[1]);
        checkOutput({ph, "_snap64"},  {63'd0, snap64}, {63'd0, expSnap});
        checkOutput({ph, "_snap4"},   {63'd0, snap4},  {63'd0, expSnap});
        checkOutput({ph, "_run64"},   {63'd0, run64},  {63'd0, mRun});
        checkOutput({ph, "_run4"},    {63'd0, run4},   {63'd0, mRun});
    endtask

    task automatic applyStimulus(input stim_t s);
        sw_en = s.sw; clear = s.clr; vinsn = s.vi; idle = s.idle;
        dmiss = s.dm; imiss = s.im; sbfull = s.sb;
        bus64.rd_req_i = s.req; bus64.rd_addr_i = s.addr;
        bus4.rd_req_i  = s.req; bus4.rd_addr_i  = s.addr;
        @(posedge clk);
        modelStep(s);
        #1;
        checkAll("cyc");
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        #1;
        modelZero();
        expValid = 1'b0;
        expData[0] = 64'd0;
        expData[1] = 64'd0;
        checkAll("rst");
        @(posedge clk);
        #1;
        checkAll("rst_hold");
        rst_ni = 1'b1;
    endtask

    task automatic readReg(input logic sw, input logic [2:0] addr);
        applyStimulus(mk(sw, 0, 0, 0, 0, 0, 0, 1, addr));
    endtask

    stim_t rs;

    initial begin
        mMax[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        mMax[1] = 64'h0000_0000_0000_000F;
        sw_en = 0; clear = 0; vinsn = 0; idle = 0; dmiss = 0; imiss = 0; sbfull = 0;
        bus64.rd_req_i = 0; bus64.rd_addr_i = 3'd0;
        bus4.rd_req_i  = 0; bus4.rd_addr_i  = 3'd0;
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] dispatch, 10 busy cycles, drain");
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        for (int c = 1; c <= 10; c++)
            applyStimulus(mk(1, 0, 0, 0, (c >= 2 && c <= 4), 0, (c == 5), 0, 3'd0));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 0, 0, 3'd0));
        checkOutput("drain_snap", {63'd0, snap64}, 64'd1);
        readReg(1, 3'd0); checkOutput("drain_rt",  bus64.rd_data_o, 64'd10);
        readReg(1, 3'd1); checkOutput("drain_dc",  bus64.rd_data_o, 64'd3);
        readReg(1, 3'd2); checkOutput("drain_ic",  bus64.rd_data_o, 64'd0);
        readReg(1, 3'd3); checkOutput("drain_sb",  bus64.rd_data_o, 64'd1);
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd0));
        checkOutput("drain_idle", {63'd0, run64}, 64'd0);

        $display("[TB] disarmed dispatch");
        applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0));
        applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        readReg(0, 3'd5); checkOutput("disarm_status", bus64.rd_data_o, 64'd1);
        readReg(0, 3'd4); checkOutput("disarm_live", bus64.rd_data_o, 64'd0);
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd0));
        checkOutput("disarm_snap", {63'd0, snap64}, 64'd1);
        readReg(0, 3'd0); checkOutput("disarm_rt", bus64.rd_data_o, 64'd0);

        $display("[TB] saturation");
        applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 3'd0));
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        for (int c = 0; c < 20; c++) applyStimulus(mk(1, 0, 0, 0, 1, 1, 1, 0, 3'd0));
        readReg(1, 3'd4);
        checkOutput("sat_live4",  {60'd0, bus4.rd_data_o}, 64'd15);
        checkOutput("sat_live64", bus64.rd_data_o, 64'd20);

        $display("[TB] clear beats dispatch and drain");
        applyStimulus(mk(1, 1, 1, 1, 0, 0, 0, 0, 3'd0));
        checkOutput("clr_run",  {63'd0, run64}, 64'd0);
        checkOutput("clr_snap", {63'd0, snap64}, 64'd0);
        for (int a = 0; a < 8; a++) begin
            readReg(0, 3'(a));
            checkOutput("clr_read64", bus64.rd_data_o, 64'd0);
            checkOutput("clr_read4", {60'd0, bus4.rd_data_o}, 64'd0);
        end

        $display("[TB] read racing a snapshot");
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        for (int c = 0; c < 3; c++) applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 0, 0, 3'd0));
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        for (int c = 0; c < 2; c++) applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        applyStimulus(mk(1, 0, 0, 1, 0, 0, 0, 1, 3'd0));
        checkOutput("race_old", bus64.rd_data_o, 64'd3);
        readReg(1, 3'd0);
        checkOutput("race_new", bus64.rd_data_o, 64'd7);

        $display("[TB] random traffic");
        rs = mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) rs.sw = ~rs.sw;
            rs.clr  = ($urandom_range(0, 59) == 0);
            rs.vi   = ($urandom_range(0, 5) == 0);
            rs.idle = ($urandom_range(0, 2) == 0);
            rs.dm   = $urandom_range(0, 1);
            rs.im   = $urandom_range(0, 1);
            rs.sb   = $urandom_range(0, 1);
            rs.req  = $urandom_range(0, 1);
            rs.addr = 3'($urandom_range(0, 7));
            applyStimulus(rs);
            if (c == 300) doReset();
        end

        $display("[TB] reset in the middle of a run");
        applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 3'd0));
        for (int c = 0; c < 5; c++) applyStimulus(mk(1, 0, 0, 0, 1, 0, 0, 0, 3'd0));
        doReset();
        applyStimulus(mk(0, 0, 0, 1, 0, 0, 0, 1, 3'd4));
        checkOutput("midrst_live", bus64.rd_data_o, 64'd0);
        checkOutput("midrst_snap", {63'd0, snap64}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
